test_err_pipe: RTL and testbench



---
 rtl/test_err_pipe.sv | 140 ++++++++++++++
 tb/tb_test_err_pipe.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/test_err_pipe.sv
// test_err_pipe: G.729 encoder excitation-error test. Scans L_exc_err over the
// zones touched by the current pitch lag, keeps the largest value, and flags
// when that value exceeds the taming threshold. A local 4096x32 scratch RAM
// holds L_exc_err; test muxes give an external host load/read access to it.
module test_err_pipe #(
  parameter logic        [11:0] L_EXC_ERR    = 12'h800,
  parameter logic signed [31:0] L_THRESH_ERR = 32'sh3FFF0000,
  parameter int                 L_SUBFR      = 40,
  parameter int                 L_INTER10    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [15:0] out,
  input  logic [15:0] T0,
  input  logic [15:0] T0_frac,
  input  logic        mem_Mux1Sel,
  input  logic        mem_Mux2Sel,
  input  logic        mem_Mux3Sel,
  input  logic        mem_Mux4Sel,
  input  logic [11:0] test_write_addr,
  input  logic [11:0] test_read_addr,
  input  logic [31:0] test_write,
  input  logic        test_write_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_READ, S_WAIT, S_CMP, S_THR, S_DONE
  } state_t;

  // Zone boundaries are multiples of the subframe length; the lag window is
  // [t1 - (L_INTER10 + L_SUBFR), t1 + (L_INTER10 - 2)].
  localparam logic signed [15:0] ZB1   = 16'(L_SUBFR);
  localparam logic signed [15:0] ZB2   = 16'(2 * L_SUBFR);
  localparam logic signed [15:0] ZB3   = 16'(3 * L_SUBFR);
  localparam logic signed [15:0] LO_OF = 16'(L_SUBFR + L_INTER10);
  localparam logic signed [15:0] HI_OF = 16'(L_INTER10 - 2);

  state_t state, state_next;

  logic signed [15:0] t0_q, t0_frac_q;
  logic        [1:0]  zone1_q, k_q;
  logic signed [31:0] maxloc_q;
  logic        [15:0] out_q;

  logic signed [15:0] t1, i1_raw, i1, i2;
  logic               flag;

  logic [31:0] mem [0:4095];
  logic [11:0] ram_wa, ram_ra;
  logic [31:0] ram_wd;
  logic        ram_we;
  logic [31:0] rd_data;

  function automatic logic [1:0] zone(input logic signed [15:0] idx);
    if (idx < ZB1)      zone = 2'd0;
    else if (idx < ZB2) zone = 2'd1;
    else if (idx < ZB3) zone = 2'd2;
    else                zone = 2'd3;
  endfunction

  // Lag window arithmetic from the latched pitch lag
  always_comb begin
    t1     = (t0_frac_q > 16'sd0) ? t0_q + 16'sd1 : t0_q;
    i1_raw = t1 - LO_OF;
    i1     = (i1_raw < 16'sd0) ? '0 : i1_raw;
    i2     = t1 + HI_OF;
    flag   = (maxloc_q > L_THRESH_ERR);
  end

  // Test-access muxes; the internal datapath only ever reads
  always_comb begin
    ram_wa = mem_Mux1Sel ? test_write_addr : '0;
    ram_ra = mem_Mux2Sel ? test_read_addr  : {L_EXC_ERR[11:2], k_q};
    ram_wd = mem_Mux3Sel ? test_write      : '0;
    ram_we = mem_Mux4Sel ? test_write_en   : 1'b0;
  end

  // Scratch RAM: synchronous write, registered read, contents survive reset
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
    rd_data <= mem[ram_ra];
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: state_next = S_READ;
      S_READ: state_next = S_WAIT;
      S_WAIT: state_next = S_CMP;
      S_CMP:  state_next = (k_q == zone1_q) ? S_THR : S_READ;
      S_THR:  state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers: lag latch, zone bounds, scan index, running maximum
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      t0_q      <= '0;
      t0_frac_q <= '0;
      zone1_q   <= '0;
      k_q       <= '0;
      maxloc_q  <= '1;
      out_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          t0_q      <= T0;
          t0_frac_q <= T0_frac;
        end
        S_CALC: begin
          zone1_q  <= zone(i1);
          k_q      <= zone(i2);
          maxloc_q <= '1;
        end
        S_CMP: begin
          if ($signed(rd_data) > maxloc_q) maxloc_q <= rd_data;
          if (k_q != zone1_q) k_q <= k_q - 2'd1;
        end
        S_THR: out_q <= {15'b0, flag};
        default: ;
      endcase
    end
  end

  assign done = (state == S_DONE);
  assign out  = out_q;

endmodule

// File: tb/tb_test_err_pipe.sv
// Directed bench for test_err_pipe: loads L_exc_err through the test muxes,
// runs lag scenarios, and compares scoreboarded results when done pulses.
module tb_test_err_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic [15:0] out;
  logic [15:0] T0, T0_frac;
  logic        mem_Mux1Sel, mem_Mux2Sel, mem_Mux3Sel, mem_Mux4Sel;
  logic [11:0] test_write_addr, test_read_addr;
  logic [31:0] test_write;
  logic        test_write_en;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  test_err_pipe dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .out(out),
    .T0(T0), .T0_frac(T0_frac),
    .mem_Mux1Sel(mem_Mux1Sel), .mem_Mux2Sel(mem_Mux2Sel),
    .mem_Mux3Sel(mem_Mux3Sel), .mem_Mux4Sel(mem_Mux4Sel),
    .test_write_addr(test_write_addr), .test_read_addr(test_read_addr),
    .test_write(test_write), .test_write_en(test_write_en)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic ram_write(input logic [11:0] addr, input logic [31:0] data);
    mem_Mux1Sel = 1'b1; mem_Mux3Sel = 1'b1; mem_Mux4Sel = 1'b1;
    test_write_addr = addr; test_write = data; test_write_en = 1'b1;
    @(posedge clock); #1;
    test_write_en = 1'b0;
    mem_Mux1Sel = 1'b0; mem_Mux3Sel = 1'b0; mem_Mux4Sel = 1'b0;
  endtask

  task automatic load_err(input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
    ram_write(12'h800, e0);
    ram_write(12'h801, e1);
    ram_write(12'h802, e2);
    ram_write(12'h803, e3);
  endtask

  // Start one computation; cycles are counted inclusively from the start cycle
  task automatic run_calc(input string tag, input logic [15:0] t0, input logic [15:0] fr,
                          input logic [15:0] expv, input int exp_lat);
    int cyc;
    logic [15:0] e;
    exp_q.push_back(expv);
    T0 = t0; T0_frac = fr; start = 1'b1;
    cyc = 1;
    do begin
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end while (!done && cyc < 40);
    if (!done) begin
      check({tag, "_timeout"}, {31'b0, done}, 32'd1);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      check({tag, "_out"}, {16'b0, out}, {16'b0, e});
      if (exp_lat > 0) check({tag, "_latency"}, cyc, exp_lat);
      @(posedge clock); #1;
      check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; T0 = '0; T0_frac = '0;
    mem_Mux1Sel = 1'b0; mem_Mux2Sel = 1'b0; mem_Mux3Sel = 1'b0; mem_Mux4Sel = 1'b0;
    test_write_addr = '0; test_read_addr = '0; test_write = '0; test_write_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_out", {16'b0, out}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Single zone, below threshold
    load_err(32'h00004000, 32'h0, 32'h0, 32'h0);
    run_calc("t1_z00", 16'd30, 16'd0, 16'h0000, 7);

    // Large error in zone 0 only
    load_err(32'h40000000, 32'h0, 32'h0, 32'h0);
    run_calc("t2_z00", 16'd30, 16'd0, 16'h0001, 7);
    run_calc("t2_z12", 16'd100, 16'd0, 16'h0000, 10);

    // Fractional lag moves window to zones 0..1
    load_err(32'h0, 32'h40000000, 32'h0, 32'h0);
    run_calc("t3_z01", 16'd60, 16'd1, 16'h0001, 10);

    // Strict threshold boundary in zone 3
    load_err(32'h0, 32'h0, 32'h0, 32'h3FFF0000);
    run_calc("t4_eq_thr", 16'd143, 16'd0, 16'h0000, 10);
    ram_write(12'h803, 32'h3FFF0001);
    run_calc("t4_gt_thr", 16'd143, 16'd0, 16'h0001, 10);

    // Negative errors never beat the -1 start value
    load_err(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    run_calc("t5_neg_z00", 16'd30, 16'd0, 16'h0000, 7);
    run_calc("t5_neg_sat", 16'd143, 16'd1, 16'h0000, 10);
    // Saturated zone still reads word 3
    ram_write(12'h803, 32'h40000000);
    run_calc("t5_sat_hit", 16'd143, 16'd1, 16'h0001, 10);
    // Negative lag-fraction keeps t1 = T0
    run_calc("t5_negfrac", 16'd143, 16'hFFFF, 16'h0001, 10);

    // Abort mid-computation with out currently 1
    exp_q.push_back(16'h0001);
    T0 = 16'd143; T0_frac = 16'd0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("t6_abort_done", {31'b0, done}, 32'd0);
    check("t6_abort_out", {16'b0, out}, 32'd0);
    exp_q.delete();
    @(posedge clock); #1;
    check("t6_held_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    run_calc("t6_after_rst", 16'd143, 16'd0, 16'h0001, 10);

    // Test-mux readback: registered read, one cycle of latency
    ram_write(12'h800, 32'h11111111);
    ram_write(12'h801, 32'hCAFEF00D);
    mem_Mux2Sel = 1'b1; test_read_addr = 12'h800;
    @(posedge clock); #1;
    check("t6_rd_800", dut.rd_data, 32'h11111111);
    test_read_addr = 12'h801;
    #1;
    check("t6_rd_hold", dut.rd_data, 32'h11111111);
    @(posedge clock); #1;
    check("t6_rd_801", dut.rd_data, 32'hCAFEF00D);
    mem_Mux2Sel = 1'b0;
    check("t6_out_mux_indep", {16'b0, out}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
